// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bus of the operand issue stage.
// The slave modport is the issue stage; the master is its producer, consumer and ALU.
interface alu_issue_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, count
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, count
  );
endinterface

// File: rtl/alu_issue.sv
// Operand issue stage: a small FIFO of {a, b, sel} ops feeding a combinational ALU,
// with the ALU result captured in a single valid/ready output register.
module alu_issue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_issue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_a_d   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_d   [DEPTH];
  logic [1:0]       mem_sel_q [DEPTH];
  logic [1:0]       mem_sel_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
    push  = bus.in_valid && !full;
    pop   = !empty && (!out_valid_q || bus.out_ready);
  end

  always_comb begin
    mem_a_d      = mem_a_q;
    mem_b_d      = mem_b_q;
    mem_sel_d    = mem_sel_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;

    if (push) begin
      mem_a_d[wr_ptr_q]   = bus.in_a;
      mem_b_d[wr_ptr_q]   = bus.in_b;
      mem_sel_d[wr_ptr_q] = bus.in_sel;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      out_result_d = bus.alu_result;
      out_valid_d  = 1'b1;
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_a_q   <= mem_a_d;
    mem_b_q   <= mem_b_d;
    mem_sel_q <= mem_sel_d;
  end

  assign bus.in_ready   = !full;
  assign bus.alu_a      = empty ? '0 : mem_a_q[rd_ptr_q];
  assign bus.alu_b      = empty ? '0 : mem_b_q[rd_ptr_q];
  assign bus.alu_sel    = empty ? 2'b00 : mem_sel_q[rd_ptr_q];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed result sequences.
module tb_alu_issue;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] sel);
    case (sel)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Stand-in for the downstream combinational ALU.
  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  op_t        model_q[$];
  logic       model_valid  = 1'b0;
  logic [3:0] model_result = 4'd0;
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         cycle        = 0;
  logic [3:0] seen[$];
  int         seen_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] sel, input logic ordy);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sel    = sel;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkSeen(input string name, input int exp_q[$]);
    checkOutput({name, "_len"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < seen.size()) checkOutput(name, seen[i], exp_q[i]);
  endtask

  // Reference model: FIFO of ops plus one output slot, advanced on each edge.
  always @(posedge clk or posedge rst) begin
    bit  do_pop;
    bit  do_push;
    op_t head;
    if (rst) begin
      model_q.delete();
      model_valid  = 1'b0;
      model_result = 4'd0;
    end else begin
      do_pop  = (model_q.size() > 0) && (!model_valid || bus.out_ready);
      do_push = bus.in_valid && (model_q.size() < DEPTH);
      if (do_pop) begin
        head         = model_q.pop_front();
        model_result = alu_ref(head.a, head.b, head.sel);
        model_valid  = 1'b1;
      end else if (model_valid && bus.out_ready) begin
        model_valid = 1'b0;
      end
      if (do_push) model_q.push_back(op_t'{a: bus.in_a, b: bus.in_b, sel: bus.in_sel});
    end
  end

  always @(negedge clk) begin
    logic [31:0] head_exp;
    cycle++;
    head_exp = (model_q.size() > 0) ? {22'd0, model_q[0]} : 32'd0;
    checkOutput("count", bus.count, model_q.size());
    checkOutput("in_ready", bus.in_ready, model_q.size() < DEPTH);
    checkOutput("out_valid", bus.out_valid, model_valid);
    checkOutput("out_result", bus.out_result, model_result);
    checkOutput("alu_head", {22'd0, bus.alu_a, bus.alu_b, bus.alu_sel}, head_exp);
    if (!rst && bus.out_valid && bus.out_ready) begin
      seen.push_back(bus.out_result);
      seen_cyc.push_back(cycle);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_stream[$];
    int exp_full[$];
    int exp_simul[$];
    int exp_wrap[$];
    int accepted;
    int tries;
    bit took;
    bit done;

    exp_stream = '{8, 12, 8, 14, 6};
    exp_full   = '{3, 4, 5, 6, 7, 8};
    exp_simul  = '{2, 4, 6, 7};
    exp_wrap   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    bus.in_valid  = 1'b0;
    bus.in_a      = 4'd0;
    bus.in_b      = 4'd0;
    bus.in_sel    = 2'b00;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_result", bus.out_result, 0);
    rst = 1'b0;

    // Reset mid-operation with three ops buffered and a pending result.
    applyStimulus(1, 4'd1, 4'd2, 2'b00, 0);
    applyStimulus(1, 4'd3, 4'd4, 2'b00, 0);
    applyStimulus(1, 4'd5, 4'd6, 2'b00, 0);
    applyStimulus(1, 4'd7, 4'd8, 2'b00, 0);
    checkOutput("pre_rst_count", bus.count, 3);
    checkOutput("pre_rst_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_count", bus.count, 0);
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 1);
    checkOutput("mid_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) applyStimulus(0, 4'd0, 4'd0, 2'b00, 1);
    checkOutput("post_rst_out_valid", bus.out_valid, 0);
    checkOutput("post_rst_seen", seen.size(), 0);

    // Streaming with the consumer always ready.
    seen.delete();
    seen_cyc.delete();
    applyStimulus(1, 4'b0011, 4'b0101, 2'b00, 1);
    checkOutput("lat_edge1_valid", bus.out_valid, 0);
    checkOutput("lat_edge1_alu_a", bus.alu_a, 4'b0011);
    applyStimulus(1, 4'b1001, 4'b0011, 2'b00, 1);
    checkOutput("lat_edge2_valid", bus.out_valid, 1);
    checkOutput("lat_edge2_result", bus.out_result, 4'b1000);
    applyStimulus(1, 4'b1100, 4'b1010, 2'b01, 1);
    applyStimulus(1, 4'b1100, 4'b1010, 2'b10, 1);
    applyStimulus(1, 4'b1100, 4'b1010, 2'b11, 1);
    repeat (5) applyStimulus(0, 4'd0, 4'd0, 2'b00, 1);
    checkSeen("stream", exp_stream);
    if (seen_cyc.size() == 5) checkOutput("stream_no_bubble", seen_cyc[4] - seen_cyc[0], 4);
    else checkOutput("stream_cycles", seen_cyc.size(), 5);

    // Fill under backpressure, then pop at full with the sixth op still offered.
    seen.delete();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.in_ready) accepted++;
      applyStimulus(1, 4'(i + 1), 4'd2, 2'b00, 0);
    end
    checkOutput("full_accepted", accepted, 5);
    checkOutput("full_count", bus.count, 4);
    checkOutput("full_in_ready", bus.in_ready, 0);
    checkOutput("full_out_result", bus.out_result, 3);
    applyStimulus(1, 4'd6, 4'd2, 2'b00, 1);
    checkOutput("popfull_count", bus.count, 3);
    checkOutput("popfull_in_ready", bus.in_ready, 1);
    checkOutput("popfull_out_result", bus.out_result, 4);
    applyStimulus(1, 4'd6, 4'd2, 2'b00, 0);
    checkOutput("refill_count", bus.count, 4);
    repeat (8) applyStimulus(0, 4'd0, 4'd0, 2'b00, 1);
    checkSeen("full_order", exp_full);

    // Simultaneous push and pop at occupancy two.
    seen.delete();
    applyStimulus(1, 4'd1, 4'd1, 2'b00, 0);
    applyStimulus(1, 4'd2, 4'd2, 2'b00, 0);
    applyStimulus(1, 4'd3, 4'd3, 2'b00, 0);
    checkOutput("simul_pre_count", bus.count, 2);
    applyStimulus(1, 4'b0101, 4'b0011, 2'b10, 1);
    checkOutput("simul_count", bus.count, 2);
    repeat (6) applyStimulus(0, 4'd0, 4'd0, 2'b00, 1);
    checkSeen("simul_order", exp_simul);

    // Pointer wrap with a randomly stalling consumer.
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      took  = 1'b0;
      tries = 0;
      while (!took && tries < 40) begin
        took = bus.in_ready;
        applyStimulus(1, 4'(i), 4'd1, 2'b00, 1'($urandom_range(0, 1)));
        tries++;
      end
      if (!took) checkOutput("wrap_push_timeout", tries, 0);
    end
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      applyStimulus(0, 4'd0, 4'd0, 2'b00, 1);
      done = (bus.count == 0) && !bus.out_valid;
    end
    checkOutput("wrap_drained", done, 1);
    checkSeen("wrap_order", exp_wrap);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Operand issue stage directly upstream of the 4-bit `alu`. It buffers {a, b, sel} operations from a producer in a small FIFO and drives the head entry onto the combinational ALU's inputs. It then registers the ALU's result into a single output stage with valid/ready handshakes on both sides. This decouples the producer from the consumer and gives a throughput of one op per cycle.

## Interface
- `WIDTH`, 4: operand and result width. It must match the ALU.
- `DEPTH`, 4: number of FIFO entries. Must be a power of 2 and at least 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  the producer offers an op.
- `in_ready`  out  1  the FIFO can accept an op.
- `in_a`  in  WIDTH  operand a.
- `in_b`  in  WIDTH  operand b.
- `in_sel`  in  2  op select: 00 add, 01 and, 10 or, 11 xor.
- `alu_a`  out  WIDTH  operand a of the head entry, wired to ALU `a`.
- `alu_b`  out  WIDTH  operand b of the head entry, wired to ALU `b`.
- `alu_sel`  out  2  select of the head entry, wired to ALU `sel`.
- `alu_result`  in  WIDTH  from ALU `result`, combinational from `alu_*`.
- `out_valid`  out  1  `out_result` holds an unconsumed result.
- `out_ready`  in  1  the consumer accepts the result.
- `out_result`  out  WIDTH  registered ALU result.
- `count`  out  clog2(DEPTH)+1  current FIFO occupancy. The output register is not counted.

## Operation
- Push: occurs when `in_valid && in_ready`. The entry is written at `wr_ptr`, and `wr_ptr` increments mod DEPTH.
- `in_ready = (count != DEPTH)`. It is combinational from state only and never depends on `in_valid`.
- Head: when `count > 0`, `alu_a`, `alu_b` and `alu_sel` show the entry at `rd_ptr`. When `count == 0`, all three are driven to 0.
- Pop: occurs when `count > 0 && (!out_valid || out_ready)`.
  - `out_result <= alu_result`.
  - `out_valid <= 1`.
  - `rd_ptr` increments mod DEPTH.
- Drain without refill: when `out_valid && out_ready` and no pop occurs, `out_valid <= 0`. `out_result` holds its value.
- Occupancy update:
  - Push and pop in the same cycle: `count` is unchanged.
  - Push only: `count + 1`.
  - Pop only: `count - 1`.
- Full: there is no push, even if a pop happens in the same cycle (no full-bypass). A pop at full frees a slot for the next cycle.
- Empty: there is no pop. There is no push-to-output bypass, so a pushed op must reach the head before it can issue.
- Width rules:
  - The ALU result is already WIDTH bits; an add carry-out is dropped by the ALU.
  - The stage does no arithmetic on data.
- Total capacity is DEPTH + 1 ops: the FIFO plus the output register.
- Ordering: strict FIFO. Results leave in push order.

## Timing
- Reset values:
  - `count` = 0, pointers = 0.
  - `in_ready` = 1.
  - `out_valid` = 0, `out_result` = 0.
  - `alu_a`, `alu_b`, `alu_sel` = 0.
  - FIFO storage contents are don't-care.
- Reset mid-operation: all buffered ops and any pending result are discarded immediately (asynchronous). The first edge after deassertion behaves as from an empty state.
- Latency: an op pushed into an empty stage at edge N appears on `alu_*` after edge N. Its result is captured at edge N+1, and `out_valid` is high after edge N+1. This is 2 edges from push to `out_valid`.
- Throughput: 1 op/cycle sustained while `out_ready` is held at 1.
- Backpressure: while `out_valid && !out_ready`, `out_result` and `out_valid` are held stable, no pop occurs, and the FIFO fills.
- `alu_*` change only on clock edges or reset. `alu_result` must settle within one cycle.

## Test plan
- Reset and idle:
  - Assert `rst` mid-sim with 3 ops buffered and `out_valid` = 1.
  - Required: immediately `count` = 0, `out_valid` = 0, `in_ready` = 1, `alu_*` = 0. No stale result appears after release.
- Stream in order with `out_ready` = 1:
  - Push (0011,0101,00), (1001,0011,00), (1100,1010,01), (1100,1010,10), (1100,1010,11) on consecutive cycles.
  - Required: `out_result` = 1000, 1100, 1000, 1110, 0110 on consecutive cycles. The first valid is 2 edges after the first push, with no bubbles.
- Full and backpressure:
  - Hold `out_ready` = 0 and push 6 ops.
  - Required: exactly 5 accepted. `in_ready` = 0 with `count` = 4. The sixth op is held by the producer. `out_result` stays at the first op's result.
- Simultaneous push and pop:
  - At `count` = 2, with `out_ready` = 1 and `in_valid` = 1 for one cycle.
  - Required: `count` stays 2 and ordering is preserved.
- Pop at full:
  - At `count` = 4 and `out_valid` = 1, raise `out_ready` for 1 cycle while `in_valid` = 1.
  - Required: no push on that edge. `count` = 3. `in_ready` = 1 on the next cycle.
- Pointer wrap:
  - Push and drain 10 ops, for example a = i, b = 1, sel = 00, with random `out_ready`.
  - Required: results are i+1 mod 16, in order, with no loss or duplication across the `rd_ptr`/`wr_ptr` wrap.
